// File: rtl/vga_fb_window_mapper.sv
// Maps the VGA raster position onto a camera-framebuffer read address (1:1, centred or 2x),
// substituting a border colour outside the camera window; 3-clock position-to-pixel latency.
module vga_fb_window_mapper #(
  parameter int              CAM_SCREEN_X = 320,
  parameter int              CAM_SCREEN_Y = 240,
  parameter int              VGA_X        = 640,
  parameter int              VGA_Y        = 480,
  parameter int              AW           = 17,
  parameter int              DW           = 8,
  parameter logic [DW-1:0]   BORDER_COLOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [9:0]    posX,
  input  logic [8:0]    posY,
  input  logic [DW-1:0] mem_data,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] pixel_out,
  output logic          in_window,
  output logic          sync_err
);

  localparam logic [9:0]  X0_CTR = 10'((VGA_X - CAM_SCREEN_X) / 2);
  localparam logic [8:0]  Y0_CTR = 9'((VGA_Y - CAM_SCREEN_Y) / 2);
  localparam logic [10:0] XW_1X  = 11'(CAM_SCREEN_X);
  localparam logic [10:0] XW_2X  = 11'(2 * CAM_SCREEN_X);
  localparam logic [9:0]  YW_1X  = 10'(CAM_SCREEN_Y);
  localparam logic [9:0]  YW_2X  = 10'(2 * CAM_SCREEN_Y);
  localparam logic [AW-1:0] ROW_STEP = AW'(CAM_SCREEN_X);

  logic [1:0]    r_mode_act;
  logic [AW-1:0] r_rb;
  logic [8:0]    r_cy;
  logic          r_win_p1;
  logic          r_win_p2;

  logic          w_frame_start;
  logic [9:0]    w_x0;
  logic [8:0]    w_y0;
  logic          w_s;
  logic [10:0]   w_x_end;
  logic [9:0]    w_y_end;
  logic          w_hit_p0;
  logic [9:0]    w_dx;
  logic [8:0]    w_dy;
  logic [9:0]    w_cx;
  logic [8:0]    w_cy;
  logic [AW-1:0] w_rb_next;
  logic          w_jump;
  logic [AW-1:0] w_addr_p0;

  assign w_frame_start = (posX == 10'd0) && (posY == 9'd0);

  // Mode 3 is reserved and falls through to top-left 1:1.
  always_comb begin
    w_x0 = '0;
    w_y0 = '0;
    w_s  = 1'b0;
    case (r_mode_act)
      2'd1: begin
        w_x0 = X0_CTR;
        w_y0 = Y0_CTR;
      end
      2'd2:    w_s = 1'b1;
      default: ;
    endcase
  end

  assign w_x_end  = {1'b0, w_x0} + (w_s ? XW_2X : XW_1X);
  assign w_y_end  = {1'b0, w_y0} + (w_s ? YW_2X : YW_1X);
  assign w_hit_p0 = (posX >= w_x0) && ({1'b0, posX} < w_x_end) &&
                    (posY >= w_y0) && ({1'b0, posY} < w_y_end);

  assign w_dx = posX - w_x0;
  assign w_dy = posY - w_y0;
  assign w_cx = w_s ? (w_dx >> 1) : w_dx;
  assign w_cy = w_s ? (w_dy >> 1) : w_dy;

  // Row base advances by one camera line instead of multiplying cy by the width.
  always_comb begin
    w_rb_next = r_rb;
    w_jump    = 1'b0;
    if (w_hit_p0) begin
      if (w_cy == 9'd0)
        w_rb_next = '0;
      else if (w_cy == r_cy + 9'd1)
        w_rb_next = r_rb + ROW_STEP;
      else if (w_cy != r_cy)
        w_jump = 1'b1;
    end
  end

  assign w_addr_p0 = w_rb_next + AW'(w_cx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_act <= 2'd0;
      r_rb       <= '0;
      r_cy       <= '0;
      addr_out   <= '0;
      r_win_p1   <= 1'b0;
      r_win_p2   <= 1'b0;
      pixel_out  <= BORDER_COLOR;
      in_window  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (w_frame_start)
        r_mode_act <= mode;
      if (w_hit_p0) begin
        r_rb <= w_rb_next;
        r_cy <= w_cy;
      end
      if (w_frame_start)
        sync_err <= 1'b0;
      else if (w_jump)
        sync_err <= 1'b1;
      // p0 -> p1: address to the RAM, window flag starts its delay line
      addr_out <= w_hit_p0 ? w_addr_p0 : '0;
      r_win_p1 <= w_hit_p0;
      // p1 -> p2: RAM performs its registered read
      r_win_p2 <= r_win_p1;
      // p2 -> p3: pixel select aligned with the RAM data
      pixel_out <= r_win_p2 ? mem_data : BORDER_COLOR;
      in_window <= r_win_p2;
    end
  end

endmodule

// File: tb/tb_vga_fb_window_mapper.sv
// Scoreboard bench for vga_fb_window_mapper: sparse raster-ordered sweeps in every mode,
// a mid-frame mode change, a row jump, and a mid-frame reset, against a behavioural RAM.
module tb_vga_fb_window_mapper;
  localparam int        AW     = 17;
  localparam int        DW     = 8;
  localparam logic [7:0] BORDER = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [9:0]    posX = '0;
  logic [8:0]    posY = '0;
  logic [DW-1:0] mem_data = '0;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] pixel_out;
  logic          in_window;
  logic          sync_err;

  vga_fb_window_mapper dut (
    .clk(clk), .rst(rst), .mode(mode), .posX(posX), .posY(posY),
    .mem_data(mem_data), .addr_out(addr_out), .pixel_out(pixel_out),
    .in_window(in_window), .sync_err(sync_err)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_f(input logic [16:0] a);
    return a[7:0] ^ {a[16:12], a[10:8]} ^ 8'h3C;
  endfunction

  always @(posedge clk) mem_data <= ram_f(addr_out);

  typedef struct { int due; int kind; int exp; string nm; } ent_t;
  ent_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic push(input int due, input int kind, input int exp, input string nm);
    ent_t e;
    e.due = due; e.kind = kind; e.exp = exp; e.nm = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0:       act = 32'(addr_out);
          1:       act = 32'(pixel_out);
          2:       act = 32'(in_window);
          default: act = 32'(sync_err);
        endcase
        n_vec++;
        if (act !== 32'(sb[i].exp)) begin
          n_bad++;
          $display("FAIL %s cyc=%0d actual=%0d required=%0d", sb[i].nm, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  typedef struct { int m; int x; int y; int a; int w; } hv_t;
  hv_t hv[10] = '{
    '{0,   5,   2,   645, 1}, '{0, 320,   0,     0, 0}, '{0,   0, 240,     0, 0},
    '{0,   5, 101, 32325, 1},
    '{1, 160, 120,     0, 1}, '{1, 479, 359, 76799, 1}, '{1, 159, 200,     0, 0},
    '{2,   3,   5,   641, 1}, '{2, 639, 479, 76799, 1}, '{2,   2,   5,   641, 1}
  };

  int cols[12] = '{0, 2, 3, 5, 159, 160, 319, 320, 479, 480, 639, 700};
  int mdl_mode = 0;
  int mdl_serr = 0;

  task automatic do_reset();
    int c;
    @(negedge clk);
    rst = 1'b1;
    c = cyc;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > c) sb.delete(i);
    mdl_mode = 0;
    mdl_serr = 0;
    push(c + 1, 0, 0, "rst_addr");
    push(c + 1, 3, 0, "rst_sync_err");
    for (int k = 1; k <= 3; k++) begin
      push(c + k, 1, int'(BORDER), "rst_pixel");
      push(c + k, 2, 0, "rst_in_window");
    end
  endtask

  task automatic step(input int x, input int y, input bit chk = 1'b1,
                      input bit jmp = 1'b0, input int hand = -1);
    int c, m, x0, y0, s, ea;
    bit hit;
    string tag;
    @(negedge clk);
    rst  = 1'b0;
    posX = 10'(x);
    posY = 9'(y);
    c    = cyc;
    m    = (mdl_mode == 3) ? 0 : mdl_mode;
    x0 = 0; y0 = 0; s = 0;
    if (m == 1) begin x0 = 160; y0 = 120; end
    if (m == 2) s = 1;
    hit = (x >= x0) && (x < x0 + (320 << s)) && (y >= y0) && (y < y0 + (240 << s));
    ea  = hit ? ((y - y0) >> s) * 320 + ((x - x0) >> s) : 0;
    if (x == 0 && y == 0) begin
      mdl_mode = int'(mode);
      mdl_serr = 0;
    end else if (jmp) begin
      mdl_serr = 1;
    end
    tag = $sformatf("m%0d(%0d,%0d)", m, x, y);
    push(c + 1, 3, mdl_serr, {"sync_err ", tag});
    if (chk) begin
      push(c + 1, 0, ea, {"addr ", tag});
      push(c + 3, 1, hit ? int'(ram_f(17'(ea))) : int'(BORDER), {"pixel ", tag});
      push(c + 3, 2, int'(hit), {"in_window ", tag});
      for (int i = 0; i < 10; i++) begin
        if (hv[i].m == m && hv[i].x == x && hv[i].y == y) begin
          push(c + 1, 0, hv[i].a, {"hand_addr ", tag});
          push(c + 3, 1, hv[i].w ? int'(ram_f(17'(hv[i].a))) : int'(BORDER), {"hand_pixel ", tag});
          push(c + 3, 2, hv[i].w, {"hand_win ", tag});
        end
      end
    end
    if (hand >= 0) begin
      push(c + 1, 0, hand, {"hand_addr ", tag});
      push(c + 3, 1, int'(ram_f(17'(hand))), {"hand_pixel ", tag});
      push(c + 3, 2, 1, {"hand_win ", tag});
    end
  endtask

  task automatic rows(input int ya, input int yb, input bit chk = 1'b1,
                      input int jmp_y = -1, input int hand_y = -1, input int hand_a = -1);
    for (int y = ya; y <= yb; y++)
      for (int k = 0; k < 12; k++)
        step(cols[k], y, chk, (y == jmp_y) && (k == 0),
             (y == hand_y && cols[k] == 5) ? hand_a : -1);
  endtask

  initial begin
    do_reset();
    mode = 2'd0; rows(0, 489);
    mode = 2'd1; rows(0, 489);
    mode = 2'd2; rows(0, 489);
    // mode request arrives mid-frame; takes effect only at the following frame
    mode = 2'd0; rows(0, 99);
    mode = 2'd2; rows(100, 489);
    rows(0, 489);
    // non-raster jump 10 -> 50: row base holds, flag sticks until frame start
    mode = 2'd0; rows(0, 10);
    rows(50, 55, 1'b0, 50, 50, 3205);
    // reset mid-frame in 2x mode falls back to top-left 1:1
    mode = 2'd2; rows(0, 30);
    do_reset();
    rows(31, 40, 1'b0, 31, 31, 5);
    rows(0, 489);
    repeat (5) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
